// File: rtl/fetch_pkg.sv
// Shared types and constants for the PC/fetch stage.
// State encoding, PC step and default reset PC.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_VALID,
    S_HALT
  } state_t;

  localparam logic [31:0] PC_STEP      = 32'd4;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_ack_timer.sv
// Ack-wait timer: clr zeroes, en counts (saturating),
// expired is high once the count equals ACK_TIMEOUT.
module fetch_ack_timer #(
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W =
    (ACK_TIMEOUT < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [W-1:0] LIM = W'(ACK_TIMEOUT);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && cnt_q != LIM) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired = (cnt_q == LIM);

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register + imem req/ack fetch sequencer feeding decode.
// Ports: in_* controls/imem ack, out_* PC/IR/flags; macro PC_ALIGN_CHECK_EN.
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEF_RESET_PC,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic        in_clk,
  input  logic        in_rst_n,
  input  logic [31:0] in_pcin,
  input  logic        in_ready,
  input  logic        in_stall,
  input  logic        in_halt,
  output logic        out_imem_req,
  output logic [31:0] out_imem_addr,
  input  logic        in_imem_ack,
  input  logic [31:0] in_imem_data,
  output logic [31:0] out_pcout,
  output logic [31:0] out_pcc,
  output logic [31:0] out_is,
  output logic        out_valid,
  output logic        out_halted,
  output logic        out_err,
  output logic        out_misalign
);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] is_q, is_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic        fetching;
  logic        expired;

  assign fetching = (state_q == S_FETCH);

  // Leaving S_FETCH clears, so every entry starts at zero.
  fetch_ack_timer #(
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_timer (
    .clk     (in_clk),
    .rst_n   (in_rst_n),
    .clr     (!fetching),
    .en      (fetching && !in_imem_ack),
    .expired (expired)
  );

`ifdef PC_ALIGN_CHECK_EN
  logic mis_q, mis_d;
  logic bad_tgt;
  assign bad_tgt = (in_pcin[1:0] != 2'b00);
`else
  logic unused_lsb;
  assign unused_lsb = ^in_pcin[1:0];
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    is_d    = is_q;
    valid_d = valid_q;
    err_d   = err_q;
`ifdef PC_ALIGN_CHECK_EN
    mis_d   = mis_q;
`endif
    unique case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        // Ack wins over a simultaneous expiry.
        if (in_imem_ack) begin
          is_d    = in_imem_data;
          valid_d = 1'b1;
          state_d = S_VALID;
        end else if (expired) begin
          err_d   = 1'b1;
          state_d = S_HALT;
        end
      end
      S_VALID: begin
        if (in_stall) begin
          state_d = S_VALID;
        end else if (in_halt) begin
          state_d = S_HALT;
`ifdef PC_ALIGN_CHECK_EN
        end else if (in_ready && bad_tgt) begin
          mis_d   = 1'b1;
          err_d   = 1'b1;
          state_d = S_HALT;
`endif
        end else if (in_ready) begin
          pc_d    = {in_pcin[31:2], 2'b00};
          valid_d = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      is_q    <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      is_q    <= is_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      mis_q <= 1'b0;
    end else begin
      mis_q <= mis_d;
    end
  end
  assign out_misalign = mis_q;
`else
  assign out_misalign = 1'b0;
`endif

  assign out_imem_req  = fetching;
  assign out_imem_addr = pc_q;
  assign out_pcout     = pc_q;
  assign out_pcc       = pc_q + PC_STEP;
  assign out_is        = is_q;
  assign out_valid     = valid_q;
  assign out_halted    = (state_q == S_HALT);
  assign out_err       = err_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: table of fetches + scoreboard,
// plus stall, halt, timeout, misalign and mid-fetch reset.
module tb_pc_fetch_unit;

  localparam int T = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pcin = '0;
  logic        ready = 1'b0;
  logic        stall = 1'b0;
  logic        halt = 1'b0;
  logic        ack = 1'b0;
  logic [31:0] data = '0;
  logic        req;
  logic [31:0] addr;
  logic [31:0] pcout, pcc, is_w;
  logic        valid, halted, err, misalign;

  pc_fetch_unit #(
    .RESET_PC    (32'h0000_0000),
    .ACK_TIMEOUT (T)
  ) dut (
    .in_clk        (clk),
    .in_rst_n      (rst_n),
    .in_pcin       (pcin),
    .in_ready      (ready),
    .in_stall      (stall),
    .in_halt       (halt),
    .out_imem_req  (req),
    .out_imem_addr (addr),
    .in_imem_ack   (ack),
    .in_imem_data  (data),
    .out_pcout     (pcout),
    .out_pcc       (pcc),
    .out_is        (is_w),
    .out_valid     (valid),
    .out_halted    (halted),
    .out_err       (err),
    .out_misalign  (misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] is;
    logic [31:0] pc;
    logic [31:0] pcc;
  } exp_t;

  typedef struct {
    logic [31:0] pcin;
    int          dly;
    logic [31:0] data;
    logic [31:0] addr;
    logic [31:0] pcc;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[6];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] cur_pc;
  logic [31:0] last_is;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic do_fetch(int dly, logic [31:0] d,
                          logic [31:0] a, logic [31:0] p);
    exp_t e;
    for (int k = 0; k <= dly; k++) begin
      chk("req_held", {31'd0, req}, 32'd1);
      chk("fetch_addr", addr, a);
      if (k == dly) begin
        ack  = 1'b1;
        data = d;
        sb.push_back('{d, a, p});
      end
      step();
    end
    ack  = 1'b0;
    data = 32'hDEAD_BEEF;
    chk("valid_after_ack", {31'd0, valid}, 32'd1);
    chk("no_err", {31'd0, err}, 32'd0);
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL sb_empty: got none want entry");
    end else begin
      e = sb.pop_front();
      chk("is", is_w, e.is);
      chk("pcout", pcout, e.pc);
      chk("pcc", pcc, e.pcc);
    end
    cur_pc  = a;
    last_is = d;
  endtask

  task automatic retire(logic [31:0] np);
    ready = 1'b1;
    pcin  = np;
    step();
    ready = 1'b0;
    chk("valid_cleared", {31'd0, valid}, 32'd0);
  endtask

  task automatic reset_and_fetch();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    do_fetch(0, 32'h2402_0005, 32'h0, 32'h4);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'h0000_0040, 3, 32'h1111_0001,
                32'h0000_0040, 32'h0000_0044};
    vecs[1] = '{32'h0000_1000, 0, 32'h2222_0002,
                32'h0000_1000, 32'h0000_1004};
    vecs[2] = '{32'h8000_0010, 2, 32'h3333_0003,
                32'h8000_0010, 32'h8000_0014};
    vecs[3] = '{32'h0000_0044, T, 32'h4444_0004,
                32'h0000_0044, 32'h0000_0048};
    vecs[4] = '{32'h0000_0044, 1, 32'h5555_0005,
                32'h0000_0044, 32'h0000_0048};
    vecs[5] = '{32'hFFFF_FFFC, 0, 32'h6666_0006,
                32'hFFFF_FFFC, 32'h0000_0000};

    // reset state
    step();
    step();
    chk("rst_req", {31'd0, req}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_mis", {31'd0, misalign}, 32'd0);
    chk("rst_pc", pcout, 32'h0);
    chk("rst_is", is_w, 32'h0);
    rst_n = 1'b1;
    step();
    do_fetch(0, 32'h2402_0005, 32'h0, 32'h4);

    for (int i = 0; i < 6; i++) begin
      retire(vecs[i].pcin);
      do_fetch(vecs[i].dly, vecs[i].data,
               vecs[i].addr, vecs[i].pcc);
    end

    // stall overrides ready for 5 cycles
    stall = 1'b1;
    ready = 1'b1;
    pcin  = 32'h0000_0200;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_req", {31'd0, req}, 32'd0);
      chk("stall_valid", {31'd0, valid}, 32'd1);
      chk("stall_pc", pcout, cur_pc);
      chk("stall_is", is_w, last_is);
    end
    stall = 1'b0;
    step();
    ready = 1'b0;
    chk("unstall_req", {31'd0, req}, 32'd1);
    chk("unstall_addr", addr, 32'h0000_0200);
    chk("unstall_valid", {31'd0, valid}, 32'd0);
    do_fetch(1, 32'h7777_0007, 32'h200, 32'h204);

    // misaligned target
    ready = 1'b1;
    pcin  = 32'h0000_0042;
    step();
    ready = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    chk("mis_flag", {31'd0, misalign}, 32'd1);
    chk("mis_err", {31'd0, err}, 32'd1);
    chk("mis_halt", {31'd0, halted}, 32'd1);
    chk("mis_pc", pcout, cur_pc);
    reset_and_fetch();
`else
    chk("mis_flag", {31'd0, misalign}, 32'd0);
    chk("mis_addr", addr, 32'h0000_0040);
    do_fetch(0, 32'h8888_0008, 32'h40, 32'h44);
`endif

    // halt beats ready
    halt  = 1'b1;
    ready = 1'b1;
    pcin  = 32'h0000_0300;
    step();
    halt  = 1'b0;
    ready = 1'b0;
    chk("halt_flag", {31'd0, halted}, 32'd1);
    chk("halt_valid", {31'd0, valid}, 32'd1);
    chk("halt_pc", pcout, cur_pc);
    chk("halt_req", {31'd0, req}, 32'd0);
    ack   = 1'b1;
    ready = 1'b1;
    step();
    step();
    ack   = 1'b0;
    ready = 1'b0;
    chk("halt_sticky", {31'd0, halted}, 32'd1);
    chk("halt_pc2", pcout, cur_pc);
    chk("halt_is2", is_w, last_is);

    // reset clears halt, then run into a timeout
    rst_n = 1'b0;
    #1;
    chk("rst2_halted", {31'd0, halted}, 32'd0);
    chk("rst2_valid", {31'd0, valid}, 32'd0);
    chk("rst2_pc", pcout, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i <= T; i++) begin
      chk("to_req", {31'd0, req}, 32'd1);
      chk("to_err_early", {31'd0, err}, 32'd0);
      step();
    end
    chk("to_err", {31'd0, err}, 32'd1);
    chk("to_halted", {31'd0, halted}, 32'd1);
    chk("to_req_off", {31'd0, req}, 32'd0);
    ack   = 1'b1;
    ready = 1'b1;
    step();
    ack   = 1'b0;
    ready = 1'b0;
    chk("to_late_valid", {31'd0, valid}, 32'd0);
    chk("to_late_halt", {31'd0, halted}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst3_err", {31'd0, err}, 32'd0);
    chk("rst3_halted", {31'd0, halted}, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // reset asserted mid-fetch, late ack ignored
    chk("mf_req", {31'd0, req}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mf_req_drop", {31'd0, req}, 32'd0);
    step();
    rst_n = 1'b1;
    ack   = 1'b1;
    data  = 32'hBAD0_0BAD;
    step();
    ack   = 1'b0;
    chk("mf_valid", {31'd0, valid}, 32'd0);
    chk("mf_is", is_w, 32'h0);
    do_fetch(0, 32'h2402_0005, 32'h0, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter register and instruction-fetch sequencer for the multi-cycle CPU. Holds the current PC, requests the instruction word from instruction memory over a req/ack handshake, and presents `out_pcout`, `out_pcc` (PC+4) and `out_is` to decode. It is the stage directly downstream of the next-PC select logic: it loads that logic's `in_pcin` result when the current instruction retires.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `ACK_TIMEOUT`, default 15: maximum cycles `out_imem_req` may wait for `in_imem_ack` before a fetch error.
- `in_clk` input, 1 bit: single clock, rising edge.
- `in_rst_n` input, 1 bit: reset, asynchronous and active-low.
- `in_pcin` input, 32 bits: next PC from next-PC select.
- `in_ready` input, 1 bit: decode accepts the presented instruction.
- `in_stall` input, 1 bit: freeze; overrides `in_ready`.
- `in_halt` input, 1 bit: the presented instruction is a halt.
- `out_imem_req` output, 1 bit: fetch request.
- `out_imem_addr` output, 32 bits: fetch address, equal to the PC.
- `in_imem_ack` input, 1 bit: memory returns data this cycle.
- `in_imem_data` input, 32 bits: instruction word, valid with ack.
- `out_pcout` output, 32 bits: PC of the presented instruction.
- `out_pcc` output, 32 bits: `out_pcout` + 4.
- `out_is` output, 32 bits: instruction register.
- `out_valid` output, 1 bit: `out_is` is valid.
- `out_halted` output, 1 bit: unit is in S_HALT.
- `out_err` output, 1 bit: sticky fetch error (timeout or misalignment).
- `out_misalign` output, 1 bit: sticky misaligned-target flag.

## Operation
- States:
  - S_IDLE: reset state; goes to S_FETCH unconditionally on the next edge.
  - S_FETCH: `out_imem_req`=1 and `out_imem_addr`=PC.
    - On `in_imem_ack`: `out_is`<=`in_imem_data`, `out_valid`<=1, go to S_VALID.
    - When the timer reaches `ACK_TIMEOUT` with no ack: `out_err`<=1, go to S_HALT.
  - S_VALID: outputs held.
    - If `in_stall`: hold everything.
    - Else if `in_halt`: go to S_HALT. The PC is not updated and `out_valid` stays 1.
    - Else if `in_ready`: PC<=`in_pcin`, `out_valid`<=0, go to S_FETCH.
  - S_HALT: terminal; left only by reset. `out_halted`=1.
- Priority in S_VALID: `in_stall` > `in_halt` > `in_ready`.
- `in_halt` and `in_ready` are ignored outside S_VALID.
- `in_imem_ack` is ignored outside S_FETCH.
- `out_pcc` = PC + 32'd4 modulo 2^32, so 32'hFFFF_FFFC produces 0.
- Timeout counter:
  - Clears on every entry to S_FETCH.
  - Increments each S_FETCH cycle without ack.
  - An ack in the same cycle the count reaches `ACK_TIMEOUT` is accepted; there is no error.
- Reset values: PC=`RESET_PC`, state=S_IDLE, `out_is`=0, `out_valid`=0, `out_err`=0, `out_misalign`=0, `out_halted`=0, `out_imem_req`=0.
- Assertion of `in_rst_n` mid-fetch abandons the request immediately (asynchronous). Any late ack is ignored because the state is S_IDLE.

## Timing
- `out_imem_req` and `out_imem_addr` are decoded combinationally from registered state and PC; there is no input-to-output combinational path.
- Reset release at edge 0: S_FETCH from edge 1, with req high during cycle 1.
- Ack sampled high at edge N: `out_valid`=1 and `out_is` updated after edge N.
- `in_ready` sampled at edge M: new PC and req high in the following cycle.
- Minimum of 2 cycles per instruction when ack arrives zero-wait.
- `out_pcout` and `out_pcc` change only on the S_VALID to S_FETCH transition.

## Configuration
- `PC_ALIGN_CHECK_EN` defined: on the S_VALID load, if `in_pcin[1:0]` != 2'b00:
  - PC is not loaded.
  - `out_misalign`<=1 and `out_err`<=1.
  - Go to S_HALT.
- `PC_ALIGN_CHECK_EN` undefined:
  - PC loads {`in_pcin[31:2]`, 2'b00}.
  - `out_misalign` is tied 0.

## Structure
- Shared package `fetch_pkg`: state encoding (S_IDLE, S_FETCH, S_VALID, S_HALT), `PC_STEP`=4, default `RESET_PC`.
- One sub-module, `fetch_ack_timer`:
  - Inputs: clear, count-enable, `ACK_TIMEOUT`.
  - Output: expired.
  - Width is $clog2(`ACK_TIMEOUT`+1).

## Test plan
- Reset, then ack in the first S_FETCH cycle with data 32'h2402_0005: `out_imem_addr`=0 during req; then `out_valid`=1, `out_is`=32'h2402_0005, `out_pcc`=4.
- `in_ready`=1 with `in_pcin`=32'h0000_0040, ack delayed 3 cycles: req held 4 cycles at address 0x40; then `out_pcout`=0x40, `out_pcc`=0x44.
- `in_stall`=1 and `in_ready`=1 for 5 cycles in S_VALID: all outputs unchanged, no req; PC loads on the first cycle with stall=0.
- No ack for `ACK_TIMEOUT`+1 cycles: `out_err`=1 and `out_halted`=1. A following ack and `in_ready` cause no change; reset clears all flags.
- `in_halt`=1 with `in_ready`=1: S_HALT, PC unchanged, `out_valid` stays 1. Also `in_pcin`=32'hFFFF_FFFC loaded: `out_pcc`=0.
- With `PC_ALIGN_CHECK_EN`, `in_pcin`=0x42: `out_misalign`=1, halted, PC unchanged. Without the macro: the fetch goes to 0x40.
